// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag positions and
// width-independent helpers used by the multiplier and its round/pack stage.
package fp_pkg;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    NAN
  } fp_class_e;

  // Bit positions inside the 4-bit {invalid, overflow, underflow, inexact} vector
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Exponent bias for a given exponent field width
  function automatic int bias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  // Returned wide so callers slice down to their own word width.
  function automatic logic [127:0] qnan(input int expW, input int manW);
    logic [127:0] v;
    v = ((128'd1 << expW) - 128'd1) << manW;
    v = v | (128'd1 << (manW - 1));
    return v;
  endfunction

  // Class from the three field tests, so it works for any field width
  function automatic fp_class_e classify(input logic expZero, input logic expOnes,
                                         input logic fracZero);
    if (expZero) begin
      return fracZero ? ZERO : SUB;
    end else if (expOnes) begin
      return fracZero ? INF : NAN;
    end
    return NORM;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and pack stage. Takes a normalised
// sign/exponent/fraction with guard, round and sticky bits and produces the
// packed word plus overflow/underflow/inexact flags. The hidden bit is
// implicit, so a carry out of the fraction means the mantissa reached 2.0.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     i_sign,
  input  logic signed [EXP_W+1:0]  i_exp,
  input  logic [MAN_W-1:0]         i_frac,
  input  logic                     i_guard,
  input  logic                     i_round,
  input  logic                     i_sticky,
  output logic [EXP_W+MAN_W:0]     o_result,
  output logic [3:0]               o_flags
);

  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [XW-1:0] EXP_MIN = '0;

  logic                 w_inc;
  logic                 w_carry;
  logic [MAN_W-1:0]     w_frac;
  logic signed [XW-1:0] w_exp;
  logic                 w_inexact;

  assign w_inc             = i_guard & (i_round | i_sticky | i_frac[0]);
  assign {w_carry, w_frac} = {1'b0, i_frac} + {{MAN_W{1'b0}}, w_inc};
  assign w_exp             = i_exp + {{(XW-1){1'b0}}, w_carry};
  assign w_inexact         = i_guard | i_round | i_sticky;

  // Saturate to infinity or flush to zero when the rounded exponent leaves the normal range
  always_comb begin
    o_result          = {i_sign, w_exp[EXP_W-1:0], w_frac};
    o_flags           = '0;
    o_flags[FLG_INX]  = w_inexact;
    if (w_exp >= EXP_MAX) begin
      o_result         = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags[FLG_OVF] = 1'b1;
      o_flags[FLG_INX] = 1'b1;
    end else if (w_exp <= EXP_MIN) begin
      o_result         = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      o_flags[FLG_UNF] = 1'b1;
      o_flags[FLG_INX] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_multiplier_pipelined.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both
// sides. Stage 1 classifies and multiplies, stage 2 normalises, stage 3
// rounds and packs. Special operands are resolved in stage 1 and ride the
// pipeline as a ready-made result that overrides the arithmetic path.
module fp_multiplier_pipelined
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_X    = XW'(bias(EXP_W));
  localparam logic [127:0]         QNAN_FULL = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];

  logic w_advance;

  logic [EXP_W-1:0]     w_aExp, w_bExp;
  logic [MAN_W-1:0]     w_aFrac, w_bFrac;
  fp_class_e            w_aCls, w_bCls;
  logic                 w_aZero, w_bZero, w_aInf, w_bInf, w_aNan, w_bNan;
  logic                 w_sign;
  logic signed [XW-1:0] w_expSum;
  logic [PW-1:0]        w_prod;
  logic                 w_special;
  logic [W-1:0]         w_specVal;
  logic [3:0]           w_specFlags;

  logic                 r_s1Valid, r_s1Sign, r_s1Special;
  logic signed [XW-1:0] r_s1Exp;
  logic [PW-1:0]        r_s1Prod;
  logic [W-1:0]         r_s1SpecVal;
  logic [3:0]           r_s1SpecFlags;

  logic                 w_msb;
  logic signed [XW-1:0] w_normExp;
  logic [MAN_W-1:0]     w_normFrac;
  logic                 w_guard, w_round, w_sticky;

  logic                 r_s2Valid, r_s2Sign, r_s2Special;
  logic signed [XW-1:0] r_s2Exp;
  logic [MAN_W-1:0]     r_s2Frac;
  logic                 r_s2Guard, r_s2Round, r_s2Sticky;
  logic [W-1:0]         r_s2SpecVal;
  logic [3:0]           r_s2SpecFlags;

  logic [W-1:0]         w_rpResult;
  logic [3:0]           w_rpFlags;

  logic                 r_outValid;
  logic [W-1:0]         r_out;
  logic [3:0]           r_flags;

  assign w_advance = !r_outValid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_outValid;
  assign out       = r_out;
  assign flags     = r_flags;

  assign w_aExp  = a[W-2:MAN_W];
  assign w_bExp  = b[W-2:MAN_W];
  assign w_aFrac = a[MAN_W-1:0];
  assign w_bFrac = b[MAN_W-1:0];
  assign w_aCls  = classify(w_aExp == '0, &w_aExp, w_aFrac == '0);
  assign w_bCls  = classify(w_bExp == '0, &w_bExp, w_bFrac == '0);

  // Subnormals are folded into zero here, which gives denormals-are-zero behaviour
  assign w_aZero = (w_aCls == ZERO) || (w_aCls == SUB);
  assign w_bZero = (w_bCls == ZERO) || (w_bCls == SUB);
  assign w_aInf  = (w_aCls == INF);
  assign w_bInf  = (w_bCls == INF);
  assign w_aNan  = (w_aCls == NAN);
  assign w_bNan  = (w_bCls == NAN);

  assign w_sign   = a[W-1] ^ b[W-1];
  assign w_expSum = $signed({2'b00, w_aExp}) + $signed({2'b00, w_bExp}) - BIAS_X;
  assign w_prod   = {{(MAN_W+1){1'b0}}, 1'b1, w_aFrac} * {{(MAN_W+1){1'b0}}, 1'b1, w_bFrac};

  // Resolve special operand combinations in priority order: NaN, inf*zero, inf, zero
  always_comb begin
    w_special   = 1'b0;
    w_specVal   = '0;
    w_specFlags = '0;
    if (w_aNan || w_bNan) begin
      w_special = 1'b1;
      w_specVal = QNAN;
    end else if ((w_aInf && w_bZero) || (w_bInf && w_aZero)) begin
      w_special            = 1'b1;
      w_specVal            = QNAN;
      w_specFlags[FLG_INV] = 1'b1;
    end else if (w_aInf || w_bInf) begin
      w_special = 1'b1;
      w_specVal = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_aZero || w_bZero) begin
      w_special = 1'b1;
      w_specVal = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  // Stage 1 register: unpacked sign, biased exponent sum, raw mantissa product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid     <= 1'b0;
      r_s1Sign      <= 1'b0;
      r_s1Exp       <= '0;
      r_s1Prod      <= '0;
      r_s1Special   <= 1'b0;
      r_s1SpecVal   <= '0;
      r_s1SpecFlags <= '0;
    end else if (w_advance) begin
      r_s1Valid     <= in_valid;
      r_s1Sign      <= w_sign;
      r_s1Exp       <= w_expSum;
      r_s1Prod      <= w_prod;
      r_s1Special   <= w_special;
      r_s1SpecVal   <= w_specVal;
      r_s1SpecFlags <= w_specFlags;
    end
  end

  // Product lies in [1,4); the MSB picks which window holds the fraction and G/R/S
  assign w_msb      = r_s1Prod[PW-1];
  assign w_normExp  = r_s1Exp + {{(XW-1){1'b0}}, w_msb};
  assign w_normFrac = w_msb ? r_s1Prod[PW-2 -: MAN_W] : r_s1Prod[PW-3 -: MAN_W];
  assign w_guard    = w_msb ? r_s1Prod[MAN_W]       : r_s1Prod[MAN_W-1];
  assign w_round    = w_msb ? r_s1Prod[MAN_W-1]     : r_s1Prod[MAN_W-2];
  assign w_sticky   = w_msb ? (|r_s1Prod[MAN_W-2:0]) : (|r_s1Prod[MAN_W-3:0]);

  // Stage 2 register: normalised fraction with guard, round and sticky bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid     <= 1'b0;
      r_s2Sign      <= 1'b0;
      r_s2Exp       <= '0;
      r_s2Frac      <= '0;
      r_s2Guard     <= 1'b0;
      r_s2Round     <= 1'b0;
      r_s2Sticky    <= 1'b0;
      r_s2Special   <= 1'b0;
      r_s2SpecVal   <= '0;
      r_s2SpecFlags <= '0;
    end else if (w_advance) begin
      r_s2Valid     <= r_s1Valid;
      r_s2Sign      <= r_s1Sign;
      r_s2Exp       <= w_normExp;
      r_s2Frac      <= w_normFrac;
      r_s2Guard     <= w_guard;
      r_s2Round     <= w_round;
      r_s2Sticky    <= w_sticky;
      r_s2Special   <= r_s1Special;
      r_s2SpecVal   <= r_s1SpecVal;
      r_s2SpecFlags <= r_s1SpecFlags;
    end
  end

  fp_round_pack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_roundPack (
    .i_sign  (r_s2Sign),
    .i_exp   (r_s2Exp),
    .i_frac  (r_s2Frac),
    .i_guard (r_s2Guard),
    .i_round (r_s2Round),
    .i_sticky(r_s2Sticky),
    .o_result(w_rpResult),
    .o_flags (w_rpFlags)
  );

  // Output register: only a valid stage-2 entry replaces the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_out      <= '0;
      r_flags    <= '0;
    end else if (w_advance) begin
      r_outValid <= r_s2Valid;
      if (r_s2Valid) begin
        r_out   <= r_s2Special ? r_s2SpecVal   : w_rpResult;
        r_flags <= r_s2Special ? r_s2SpecFlags : w_rpFlags;
      end
    end
  end

endmodule

// File: tb/tb_fp_multiplier_pipelined.sv
// Directed bench for the pipelined multiplier: reset state, FP32 products,
// rounding, specials, overflow/underflow, streaming, backpressure, reset with
// work in flight, and a half-precision instance.
module tb_fp_multiplier_pipelined;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INX  = 4'b0001;
  localparam logic [3:0] F_UNF  = 4'b0010;
  localparam logic [3:0] F_OVF  = 4'b0100;
  localparam logic [3:0] F_INV  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic [3:0]  flags;

  logic        hInValid, hInReady, hOutValid, hOutReady;
  logic [15:0] hA, hB, hOut;
  logic [3:0]  hFlags;

  int checks = 0;
  int errors = 0;

  logic [31:0] bpB[5];
  logic [31:0] bpExp[5];
  int          sent, recv, stallLeft;
  bit          stallStarted, inXfer;

  always #5 clk = ~clk;

  fp_multiplier_pipelined #(.EXP_W(8), .MAN_W(23)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .flags    (flags)
  );

  fp_multiplier_pipelined #(.EXP_W(5), .MAN_W(10)) dutHalf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (hInValid),
    .in_ready (hInReady),
    .a        (hA),
    .b        (hB),
    .out_valid(hOutValid),
    .out_ready(hOutReady),
    .out      (hOut),
    .flags    (hFlags)
  );

  task automatic checkEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB);
    in_valid = 1'b1;
    a        = opA;
    b        = opB;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expOut, input logic [3:0] expFlags);
    checkEq({tag, "/valid"}, 64'(out_valid), 64'(1'b1));
    checkEq({tag, "/out"},   64'(out),       64'(expOut));
    checkEq({tag, "/flags"}, 64'(flags),     64'(expFlags));
  endtask

  task automatic runVector(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                           input logic [31:0] expOut, input logic [3:0] expFlags);
    applyStimulus(opA, opB);
    @(negedge clk);
    checkEq({tag, "/early"}, 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    checkOutput(tag, expOut, expFlags);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    hInValid  = 1'b0;
    hA        = '0;
    hB        = '0;
    hOutReady = 1'b1;
    bpB   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    bpExp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};

    repeat (2) @(negedge clk);
    checkEq("reset/outValid", 64'(out_valid), 64'(1'b0));
    checkEq("reset/out",      64'(out),       64'(32'h0));
    checkEq("reset/flags",    64'(flags),     64'(4'h0));
    rst_n = 1'b1;
    #1;
    checkEq("reset/inReady", 64'(in_ready), 64'(1'b1));
    @(negedge clk);

    runVector("mul2x3",    32'h40000000, 32'h40400000, 32'h40C00000, F_NONE);
    runVector("mul1p5sq",  32'h3FC00000, 32'h3FC00000, 32'h40100000, F_NONE);
    runVector("rndLow",    32'h3F800001, 32'h3F800001, 32'h3F800002, F_INX);
    runVector("rndUp",     32'h3F800003, 32'h3F800001, 32'h3F800004, F_INX);
    runVector("infXzero",  32'h7F800000, 32'h00000000, 32'h7FC00000, F_INV);
    runVector("negInfX2",  32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE);
    runVector("daz",       32'h00000001, 32'h40000000, 32'h00000000, F_NONE);
    runVector("nanIn",     32'h7FC00001, 32'h40000000, 32'h7FC00000, F_NONE);
    runVector("overflow",  32'h7F7FFFFF, 32'h40000000, 32'h7F800000, F_OVF | F_INX);
    runVector("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, F_UNF | F_INX);

    // Back-to-back stream with the consumer always ready: one result per cycle
    in_valid = 1'b1; a = 32'h40000000; b = 32'h40400000;
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h3FC00000;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("stream0", 32'h40C00000, F_NONE);
    @(negedge clk);
    checkOutput("stream1", 32'h40100000, F_NONE);
    @(negedge clk);
    checkOutput("stream2", 32'h40800000, F_NONE);
    @(negedge clk);
    checkEq("stream/drained", 64'(out_valid), 64'(1'b0));

    // Five operand pairs with a four-cycle consumer stall after the first result
    sent = 0; recv = 0; stallLeft = 0; stallStarted = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      in_valid = (sent < 5);
      a        = 32'h40000000;
      if (sent < 5) b = bpB[sent];
      if (!stallStarted && out_valid) begin
        stallStarted = 1'b1;
        stallLeft    = 4;
      end
      out_ready = (stallLeft == 0);
      #1;
      if (stallLeft > 0) begin
        checkEq("bp/inReadyLow", 64'(in_ready),  64'(1'b0));
        checkEq("bp/outHeld",    64'(out),       64'(bpExp[recv]));
        checkEq("bp/validHeld",  64'(out_valid), 64'(1'b1));
        stallLeft--;
      end
      inXfer = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checkEq("bp/result", 64'(out), 64'(bpExp[recv]));
        recv++;
      end
      @(negedge clk);
      if (inXfer) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkEq("bp/count", 64'(recv), 64'(5));
    @(negedge clk);
    checkEq("bp/noDup", 64'(out_valid), 64'(1'b0));

    // Three results in flight when reset hits; none may survive it
    in_valid = 1'b1; a = 32'h40000000; b = 32'h40400000;
    @(negedge clk);
    b = 32'h40800000;
    @(negedge clk);
    b = 32'h40A00000;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkEq("rst/outValid", 64'(out_valid), 64'(1'b0));
    checkEq("rst/out",      64'(out),       64'(32'h0));
    checkEq("rst/flags",    64'(flags),     64'(4'h0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq("rst/noStale", 64'(out_valid), 64'(1'b0));
    end

    // Half-precision instance: 2.0 * 3.0 = 6.0
    hInValid = 1'b1; hA = 16'h4000; hB = 16'h4200;
    @(negedge clk);
    hInValid = 1'b0;
    @(negedge clk);
    checkEq("half/early", 64'(hOutValid), 64'(1'b0));
    @(negedge clk);
    checkEq("half/valid", 64'(hOutValid), 64'(1'b1));
    checkEq("half/out",   64'(hOut),      64'(16'h4600));
    checkEq("half/flags", 64'(hFlags),    64'(4'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
